// File: rtl/noc_fifo_pkg.sv
// Shared helpers for the NoC input-port FIFOs: safe clog2, shared-pool sizing
// and the default entry-index type.
package noc_fifo_pkg;

    localparam int unsigned DEF_DEPTH = 8;

    function automatic int unsigned clog2safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Entries left for the shared pool once every channel has its reservation.
    function automatic int unsigned shared_slots(input int unsigned depth,
                                                 input int unsigned nch,
                                                 input int unsigned rsv);
        return (depth > nch * rsv) ? depth - nch * rsv : 0;
    endfunction

    typedef logic [clog2safe(DEF_DEPTH)-1:0] entry_idx_t;

endpackage

// File: rtl/shared_slot_alloc.sv
// Cascaded find-first-free allocator: each admitted writer, in index order,
// takes the lowest entry not occupied and not taken by a lower-index writer.
module shared_slot_alloc
    import noc_fifo_pkg::*;
#(
    parameter int unsigned NCH   = 6,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IW    = clog2safe(DEPTH)
) (
    input  logic [DEPTH-1:0]        occupied,
    input  logic [NCH-1:0]          req,
    input  logic [NCH-1:0]          admit,
    output logic [NCH-1:0][IW-1:0]  idx,
    output logic [DEPTH-1:0]        new_mask
);

    always_comb begin
        logic [DEPTH-1:0] taken;
        logic             found;
        taken    = occupied;
        new_mask = '0;
        idx      = '0;
        found    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            found = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (!found && !taken[j]) begin
                    idx[i] = IW'(j);
                    found  = 1'b1;
                end
            end
            if (req[i] && admit[i] && found) begin
                taken[idx[i]]    = 1'b1;
                new_mask[idx[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/syncfifo.sv
// Small synchronous FIFO with synchronous clear; used as a per-channel queue
// of buffer entry indices.
module syncfifo
    import noc_fifo_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned D  = 8,
    parameter int unsigned CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout_c,
    output logic          empty_c,
    output logic          full_c,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = clog2safe(D);

    logic [W-1:0]  mem_q [D];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop, do_push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(D - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CW'(D)) || do_pop);
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (clr) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_q] <= din;
    end

    assign dout_c  = mem_q[rd_q];
    assign empty_c = (cnt_q == '0);
    assign full_c  = (cnt_q == CW'(D));
    assign count   = cnt_q;

    // A push must never be dropped.
    always @(posedge clk) begin
        if (rst_n) assert (!(push && !clr && !do_push));
    end

endmodule

// File: rtl/syncfifo_shared_rsv.sv
// Multi-channel FIFO: NCH logical queues over one DEPTH-entry buffer, with
// RSV reserved entries per channel and a priority-arbitrated shared pool.
module syncfifo_shared_rsv
    import noc_fifo_pkg::*;
#(
    parameter int unsigned WID   = 128,
    parameter int unsigned NCH   = 6,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned RSV   = 1,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     softreset,
    input  logic [NCH-1:0]           vldin,
    input  logic [NCH-1:0][WID-1:0]  din,
    output logic [NCH-1:0]           accepted,
    input  logic [NCH-1:0]           readout,
    output logic [NCH-1:0][WID-1:0]  dout,
    output logic [NCH-1:0]           empty,
    output logic [NCH-1:0]           full,
    output logic [NCH-1:0][CW-1:0]   chan_count,
    output logic [15:0]              count
);

    localparam int unsigned IW     = clog2safe(DEPTH);
    localparam int unsigned SHARED = shared_slots(DEPTH, NCH, RSV);

    logic [DEPTH-1:0]         occupied_q, occupied_d;
    logic [DEPTH-1:0]         new_mask, free_mask;
    logic [WID-1:0]           buf_q [DEPTH];
    logic [NCH-1:0]           grant, pop, ch_empty, ptr_full;
    logic [NCH-1:0][IW-1:0]   alloc_idx, head_idx;

    // Admission: reserved slots first, shared pool handed out lowest index first.
    always_comb begin
        int unsigned used;
        int unsigned rem;
        int unsigned cnt;
        used  = 0;
        rem   = 0;
        cnt   = 0;
        full  = '0;
        grant = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt = 32'(chan_count[i]);
            if (cnt > RSV) used = used + (cnt - RSV);
        end
        rem = (SHARED > used) ? SHARED - used : 0;
        for (int i = 0; i < NCH; i++) begin
            cnt     = 32'(chan_count[i]);
            full[i] = (cnt >= RSV) && (used == SHARED);
            if (vldin[i] && !full[i] && !softreset) begin
                if (cnt < RSV) begin
                    grant[i] = 1'b1;
                end else if (rem > 0) begin
                    grant[i] = 1'b1;
                    rem      = rem - 1;
                end
            end
        end
    end

    assign accepted = grant;
    assign pop      = readout & ~ch_empty;

    shared_slot_alloc #(
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_alloc (
        .occupied (occupied_q),
        .req      (vldin),
        .admit    (grant),
        .idx      (alloc_idx),
        .new_mask (new_mask)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        syncfifo #(
            .W  (IW),
            .D  (DEPTH),
            .CW (CW)
        ) u_ptr (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (softreset),
            .push    (grant[g]),
            .din     (alloc_idx[g]),
            .pop     (pop[g]),
            .dout_c  (head_idx[g]),
            .empty_c (ch_empty[g]),
            .full_c  (ptr_full[g]),
            .count   (chan_count[g])
        );
    end

    // Entries freed by pops become allocatable only after the edge.
    always_comb begin
        free_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pop[i]) free_mask[head_idx[i]] = 1'b1;
        end
        occupied_d = softreset ? '0 : ((occupied_q & ~free_mask) | new_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occupied_q <= '0;
        else        occupied_q <= occupied_d;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) buf_q[alloc_idx[i]] <= din[i];
        end
    end

    always_comb begin
        dout  = '0;
        count = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!ch_empty[i]) dout[i] = buf_q[head_idx[i]];
            count = count + 16'(chan_count[i]);
        end
    end

    assign empty = ch_empty;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (DEPTH >= NCH * RSV);
            assert (32'(count) <= DEPTH);
            assert ($countones(occupied_q) == 32'(count));
            assert ((new_mask & occupied_q) == '0);
            assert ($countones(new_mask) == $countones(grant));
            for (int i = 0; i < NCH; i++) begin
                assert (!(grant[i] && ptr_full[i] && !pop[i]));
            end
        end
    end

endmodule
